// File: rtl/sram_stream_pkg.sv
// -----------------------------------------------------------------------------
// sram_stream_pkg
//
// Shared definitions for the SRAM read streamer:
//   SRAM_DW    - SRAM word width (32)
//   SRAM_AW    - SRAM address width (7, i.e. 128 words)
//   rd_state_t - read sequencer state (IDLE, RUN, DRAIN)
// -----------------------------------------------------------------------------
package sram_stream_pkg;

    localparam int SRAM_DW = 32;
    localparam int SRAM_AW = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/stream_buf2.sv
// -----------------------------------------------------------------------------
// stream_buf2
//
// Two-entry synchronous FIFO that holds SRAM read data until the downstream
// stream accepts it. The caller guarantees no push when full (unless it pops
// in the same cycle) and no pop when empty.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (clears pointers and count)
//   push       in   write push_data on this edge
//   push_data  in   DW  data to write
//   pop        in   drop the head entry on this edge
//   pop_data   out  DW  head entry (meaningful when occ != 0)
//   occ        out  2   number of stored entries, 0..2
// -----------------------------------------------------------------------------
module stream_buf2 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [1:0]    cnt_q, cnt_d;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it has been written, and the count already says empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_q];
    assign occ      = cnt_q;

endmodule

// File: rtl/sram_rd_streamer.sv
// -----------------------------------------------------------------------------
// sram_rd_streamer
//
// Read-side sequencer for the 32 x 128 SRAM. A start command issues len
// consecutive reads from base_addr (address wraps modulo 2**AW), absorbs the
// one-cycle SRAM read latency in a 2-entry buffer and presents the words on a
// valid/ready stream. One word per cycle when unstalled, no loss or
// duplication under backpressure.
//
// Ports:
//   CLK        in   clock
//   RESET      in   synchronous active-high reset
//   start      in   command strobe, accepted only when idle
//   base_addr  in   AW    first word address (sampled with start)
//   len        in   AW+1  word count 0..2**AW (sampled with start)
//   busy       out  transfer in progress (RUN or DRAIN)
//   done       out  one-cycle completion pulse
//   sram_CEN   out  SRAM chip enable, active low
//   sram_WEN   out  SRAM write enable, tied high (read only)
//   sram_A     out  AW    SRAM address
//   sram_Q     in   DW    SRAM read data, valid the cycle after the address
//   out_data   out  DW    stream data
//   out_valid  out  stream valid
//   out_ready  in   stream ready
//   stall_cnt  out  16    cycles with out_valid && !out_ready (only when
//                         SRAM_RD_STREAMER_STALL_CNT_EN is defined); cleared
//                         on reset and on each accepted start, saturating
// -----------------------------------------------------------------------------
module sram_rd_streamer
    import sram_stream_pkg::*;
#(
    parameter int DW = SRAM_DW,
    parameter int AW = SRAM_AW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          sram_CEN,
    output logic          sram_WEN,
    output logic [AW-1:0] sram_A,
    input  logic [DW-1:0] sram_Q,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
`ifdef SRAM_RD_STREAMER_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   REMAIN_ONE = {{AW{1'b0}}, 1'b1};

    rd_state_t     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;      // next address to read
    logic [AW-1:0] a_q, a_d;            // address presented on the last issue
    logic [AW:0]   remain_q, remain_d;  // reads still to issue
    logic          pend_q, pend_d;      // read issued last cycle, data on sram_Q now
    logic          done_q, done_d;

    logic [1:0]    occ;
    logic          pop;
    logic          issue;
    logic [2:0]    level;

    // Words that will be held after this edge: buffered + arriving - leaving.
    // Keeping this below 2 means the buffer can never overflow.
    assign pop   = out_valid && out_ready;
    assign level = {1'b0, occ} + {2'b0, pend_q} - {2'b0, pop};
    assign issue = (state_q == RUN) && (remain_q != '0) && (level < 3'd2);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        a_d      = a_q;
        remain_d = remain_q;
        pend_d   = issue;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = len;
                    if (len != '0) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    a_d      = addr_q;
                    addr_d   = addr_q + ADDR_ONE;  // wraps at 2**AW
                    remain_d = remain_q - REMAIN_ONE;
                    if (remain_q == REMAIN_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Nothing in flight and the buffer empties on this edge.
                if (level == 3'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            a_q      <= '0;
            remain_q <= '0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            a_q      <= a_d;
            remain_q <= remain_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
        end
    end

    stream_buf2 #(
        .DW (DW)
    ) u_buf (
        .clk       (CLK),
        .rst       (RESET),
        .push      (pend_q),
        .push_data (sram_Q),
        .pop       (pop),
        .pop_data  (out_data),
        .occ       (occ)
    );

    assign out_valid = (occ != 2'd0);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign sram_CEN  = !issue;
    assign sram_WEN  = 1'b1;
    // Present the new address while issuing, otherwise hold the last one.
    assign sram_A    = issue ? addr_q : a_q;

`ifdef SRAM_RD_STREAMER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            stall_d = 16'd0;
        end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/sram_rd_streamer.md
# sram_rd_streamer

Read-side sequencer for the 32-bit x 128-word activation/weight SRAM: on a `start` command it issues `len` consecutive reads from `base_addr`, absorbs the SRAM's one-cycle read latency, and presents words on a valid/ready stream to the downstream L0/input FIFO. It sits directly downstream of the SRAM macro and drives its CEN/WEN/A pins. Full backpressure is supported without losing or duplicating words, at one word per cycle when unstalled.

## Interface
- `DW`, 32, data width (must match SRAM word).
- `AW`, 7, SRAM address width; depth = 2**AW.
- `CLK`  in  1  clock; all state changes on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; accepted only in IDLE.
- `base_addr`  in  AW  first word address, sampled with `start`.
- `len`  in  AW+1  words to read, 0..2**AW, sampled with `start`.
- `busy`  out  1  high in RUN/DRAIN.
- `done`  out  1  one-cycle pulse at transfer completion.
- `sram_CEN`  out  1  SRAM chip enable, active-low.
- `sram_WEN`  out  1  constant 1 (read only).
- `sram_A`  out  AW  SRAM address.
- `sram_Q`  in  DW  SRAM read data (valid the cycle after the address edge).
- `out_data`  out  DW  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready; transfer when valid && ready.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on `start` && `len`!=0.
  - IDLE stays IDLE on `start` && `len`==0, with `done` pulsed next cycle.
  - RUN -> DRAIN when the last read is issued.
  - DRAIN -> IDLE once no read is pending and the buffer is empty; `done` pulses in the cycle after that edge.
- `start` while busy is ignored; `base_addr`/`len` are not re-sampled.
- Read issue: `issue` = RUN && remaining!=0 && (occ + pend − pop) < 2.
  - `occ` = buffer occupancy (0..2).
  - `pend` = read issued last cycle.
  - `pop` = out_valid && out_ready.
  - `issue` is combinational; `sram_CEN` = !issue.
- On each issue, address increments modulo 2**AW (wraps 127 -> 0) and remaining decrements.
- `sram_A` holds its last value when not issuing.
- When `pend` is set, `sram_Q` is written into a 2-entry FIFO on that edge. `out_data` comes from the FIFO head; `out_valid` = occ!=0.
- Words are emitted in address order, exactly `len` of them, with no drop or duplicate under any `out_ready` pattern.
- RESET, including mid-transfer:
  - State -> IDLE; buffer and `pend` are cleared.
  - `busy`=0, `done`=0, `out_valid`=0, `sram_CEN`=1, `sram_A`=0.
  - No `done` is pulsed for the aborted transfer.

## Timing
- `start` high at edge e0: `sram_CEN` goes low in cycle e0–e1; the first word is `out_valid` after e2, a 2-cycle latency.
- With `out_ready` held high, there is one word per cycle. The last word is valid after e(len+1), and `done` is high after e(len+2).
- `out_ready` low: at most 2 words are buffered, and issue stops when occ+pend reaches 2. Throughput resumes the cycle `out_ready` returns.
- `done` and `start` in the same cycle: the new `start` is accepted, since the FSM is already IDLE.

## Configuration
- `SRAM_RD_STREAMER_STALL_CNT_EN` defined: adds output `stall_cnt` [15:0].
  - Counts cycles with out_valid && !out_ready.
  - Cleared by RESET and on each accepted `start`; saturates at 16'hFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Package `sram_stream_pkg` holds:
  - the state enum `rd_state_t` {IDLE, RUN, DRAIN};
  - constants `SRAM_DW`=32, `SRAM_AW`=7.
- Sub-module `stream_buf2`: 2-entry synchronous FIFO with push/pop, occupancy output, and synchronous reset.
- Address counter, FSM and issue logic live in the top.

## Test plan
- Preload mem[i]=32'hA000_0000+i; base=5, len=4, out_ready=1 -> outputs A..05..A..08 on consecutive cycles, 2 cycles after start; `done` 1 cycle after the last word; exactly 4 CEN-low cycles.
- base=126, len=4 -> data from addresses 126, 127, 0, 1 in that order.
- len=10 with out_ready toggling 1,0,0,1 repeatedly -> all 10 words in order, none duplicated; never more than 2 buffered; CEN high while stalled.
- len=0 -> `done` pulse, no CEN-low cycle, no out_valid.
- RESET asserted 3 cycles into a len=20 transfer -> next cycle out_valid=0, busy=0, CEN=1; a fresh start base=0, len=2 then completes normally.
- With macro defined: len=3, out_ready low for 5 cycles after the first valid -> stall_cnt=5 at done.
